// File: rtl/droplet_mux_sequencer.sv
// droplet_mux_sequencer
// Drives the two valve lines of the dual-source droplet mux with break-before-make
// timing. The host asks for a number of droplets from a starting source and can ask
// for the source to alternate after every droplet. Each droplet is one SETTLE
// window with both valves closed, followed by one OPEN window on the selected path.
// A final SETTLE window follows the last droplet, so both valves are closed when
// done pulses.
//
// Optional feature: define DROPLET_MUX_SEQUENCER_ABORT_EN to add the abort input.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready only while IDLE)
//   req_src            starting source: 0 = cp1 path, 1 = cp2 path
//   req_alt            1 = toggle the source after every droplet
//   req_count          number of droplets to dispense
//   abort              (optional) stop after the current SETTLE window
//   cp1, cp2           registered valve controls, 1 = open
//   busy               request in SETTLE/OPEN
//   done               one-cycle completion pulse
//   droplets_out       droplets completed in the current/last request
module droplet_mux_sequencer #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DISPENSE_CYCLES = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_src,
  input  logic             req_alt,
  input  logic [CNT_W-1:0] req_count,
`ifdef DROPLET_MUX_SEQUENCER_ABORT_EN
  input  logic             abort,
`endif
  output logic             cp1,
  output logic             cp2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] droplets_out
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > DISPENSE_CYCLES) ? SETTLE_CYCLES
                                                                      : DISPENSE_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] OPEN_LOAD   = TMR_W'(DISPENSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, OPEN, DONE} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] drops_d;
  logic             src_q, src_d;
  logic             alt_q, alt_d;
  logic             cp1_d, cp2_d, busy_d, done_d, ready_d;
  logic             accept_c;
  logic             abort_c;

`ifdef DROPLET_MUX_SEQUENCER_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // req_ready is only ever high in IDLE, so it doubles as the state qualifier.
  assign accept_c = req_valid && req_ready;

  // State, timer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      rem_q        <= '0;
      src_q        <= 1'b0;
      alt_q        <= 1'b0;
      droplets_out <= '0;
      cp1          <= 1'b0;
      cp2          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      req_ready    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      rem_q        <= rem_d;
      src_q        <= src_d;
      alt_q        <= alt_d;
      droplets_out <= drops_d;
      cp1          <= cp1_d;
      cp2          <= cp2_d;
      busy         <= busy_d;
      done         <= done_d;
      req_ready    <= ready_d;
    end
  end

  // Next state and next register values; outputs decode the next state so they are
  // registered yet aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    src_d   = src_q;
    alt_d   = alt_q;
    drops_d = droplets_out;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          src_d   = req_src;
          alt_d   = req_alt;
          rem_d   = req_count;
          drops_d = '0;
          tmr_d   = SETTLE_LOAD;
          state_d = (req_count == '0) ? DONE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort_c) begin
          // Restart the closed window so the valves stay shut a full SETTLE.
          tmr_d = SETTLE_LOAD;
          rem_d = '0;
        end else if (tmr_q == '0) begin
          if (rem_q != '0) begin
            state_d = OPEN;
            tmr_d   = OPEN_LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      OPEN: begin
        if (abort_c) begin
          // The droplet in flight is abandoned and not counted.
          state_d = SETTLE;
          tmr_d   = SETTLE_LOAD;
          rem_d   = '0;
        end else if (tmr_q == '0) begin
          drops_d = droplets_out + CNT_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          src_d   = src_q ^ alt_q;
          state_d = SETTLE;
          tmr_d   = SETTLE_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cp1_d   = (state_d == OPEN) && !src_d;
    cp2_d   = (state_d == OPEN) && src_d;
    busy_d  = (state_d == SETTLE) || (state_d == OPEN);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

endmodule
